fp_posit4_acc2fp16: RTL and testbench

Output-side converter for the fp16×posit4 MAC datapath. It takes the accumulator's (exponent, two's-complement fixed-point) result plus its NaR flag and re-encodes it as an IEEE fp16 word. It uses a small FSM with bit-serial leading-zero normalisation and round-to-nearest-even. It sits between the MAC accumulator output and the activation write-back path, and is the inverse of the fp16-to-fixed expansion done at the MAC input.

---
 rtl/fp_posit4_acc2fp16.sv | 161 ++++++++++++++++
 tb/tb_fp_posit4_acc2fp16.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_posit4_acc2fp16.sv
// Re-encodes the MAC accumulator (biased exponent + two's-complement fixed point, NaR flag) as IEEE fp16, RNE.
// Latency: done after E(lz+3) counted from the start edge E0; NaR/zero results after E2.
// Backpressure: none; start is ignored while busy, and back-to-back starts are accepted in the done cycle.
module fp_posit4_acc2fp16 #(
  parameter int ACC_WIDTH = 32,
  parameter int FRAC_BITS = 14,
  parameter int EXP_BIAS  = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4:0]           exp_in,
  input  logic [ACC_WIDTH-1:0] fixed_point_in,
  input  logic                 NaR_in,
  output logic                 busy,
  output logic [15:0]          fp16_out,
  output logic                 done,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int LZW       = $clog2(ACC_WIDTH);
  localparam int FP16_BIAS = 15;
  // Exponent of the normalised msb, rebased from the accumulator bias to the fp16 bias.
  localparam int E_OFS     = FP16_BIAS - EXP_BIAS + ACC_WIDTH - 1 - FRAC_BITS;
  // Bit position of the guard bit once the leading one sits in the msb.
  localparam int GRD       = ACC_WIDTH - 12;

  typedef enum logic [1:0] {IDLE, ABS, NORM, ROUND} state_t;

  state_t                 state_q, state_d;
  logic [4:0]             exp_q, exp_d;
  logic [ACC_WIDTH-1:0]   fixed_q, fixed_d;
  logic                   nar_q, nar_d;
  logic                   sign_q, sign_d;
  logic [ACC_WIDTH-1:0]   mag_q, mag_d;
  logic [LZW-1:0]         lz_q, lz_d;
  logic [15:0]            fp16_q, fp16_d;
  logic                   done_q, done_d;
  logic                   ovf_q, ovf_d;
  logic                   udf_q, udf_d;

  logic [9:0]             mant;
  logic                   guard;
  logic                   sticky;
  logic                   rnd_up;
  logic [10:0]            mant_r;
  logic signed [9:0]      e_pre;
  logic signed [9:0]      e_fin;

  // Rounding datapath: works on the normalised magnitude; only consumed in ROUND.
  always_comb begin
    mant   = mag_q[ACC_WIDTH-2 -: 10];
    guard  = mag_q[GRD];
    sticky = |mag_q[GRD-1:0];
    rnd_up = guard & (sticky | mant[0]);
    mant_r = {1'b0, mant} + {10'b0, rnd_up};
    e_pre  = $signed({5'b0, exp_q}) + $signed(10'(E_OFS))
             - $signed({{(10-LZW){1'b0}}, lz_q});
    // A carry out of the mantissa leaves mant_r[9:0] all zero, so only the exponent moves.
    e_fin  = e_pre + $signed({9'b0, mant_r[10]});
  end

  // Next-state and datapath update for the IDLE/ABS/NORM/ROUND sequence.
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    fixed_d = fixed_q;
    nar_d   = nar_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    lz_d    = lz_q;
    fp16_d  = fp16_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          exp_d   = exp_in;
          fixed_d = fixed_point_in;
          nar_d   = NaR_in;
          state_d = ABS;
        end
      end
      ABS: begin
        sign_d = fixed_q[ACC_WIDTH-1];
        // The most negative input negates to itself, which is the correct unsigned magnitude.
        mag_d  = fixed_q[ACC_WIDTH-1] ? (~fixed_q + ACC_WIDTH'(1)) : fixed_q;
        lz_d   = '0;
        // NaR and zero skip normalisation; ROUND recognises them from nar_q / mag_q.
        if (nar_q || (fixed_q == '0)) state_d = ROUND;
        else                          state_d = NORM;
      end
      NORM: begin
        if (mag_q[ACC_WIDTH-1]) begin
          state_d = ROUND;
        end else begin
          mag_d = mag_q << 1;
          lz_d  = lz_q + LZW'(1);
        end
      end
      ROUND: begin
        done_d  = 1'b1;
        state_d = IDLE;
        ovf_d   = 1'b0;
        udf_d   = 1'b0;
        if (nar_q) begin
          fp16_d = 16'h7E00;
        end else if (mag_q == '0) begin
          fp16_d = 16'h0000;
        end else if (e_fin >= 10'sd31) begin
          fp16_d = {sign_q, 5'h1F, 10'h000};
          ovf_d  = 1'b1;
        end else if (e_fin <= 10'sd0) begin
          fp16_d = {sign_q, 15'h0000};
          udf_d  = 1'b1;
        end else begin
          fp16_d = {sign_q, e_fin[4:0], mant_r[9:0]};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      exp_q   <= '0;
      fixed_q <= '0;
      nar_q   <= 1'b0;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      lz_q    <= '0;
      fp16_q  <= 16'h0000;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      fixed_q <= fixed_d;
      nar_q   <= nar_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      lz_q    <= lz_d;
      fp16_q  <= fp16_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign fp16_out  = fp16_q;
  assign done      = done_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule

// File: tb/tb_fp_posit4_acc2fp16.sv
// Bench for the accumulator-to-fp16 converter: value-level reference model plus per-cycle compare.
// Latency: model predicts the done edge from the leading-one position of the magnitude.
// Backpressure: starts are issued in the done cycle to exercise back-to-back acceptance.
module tb_fp_posit4_acc2fp16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  exp_in;
  logic [31:0] fixed_point_in;
  logic        NaR_in;
  logic        busy;
  logic [15:0] fp16_out;
  logic        done;
  logic        overflow;
  logic        underflow;

  int checks   = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  fp_posit4_acc2fp16 #(.ACC_WIDTH(32), .FRAC_BITS(14), .EXP_BIAS(15)) dut (
    .clk(clk), .rst(rst), .start(start), .exp_in(exp_in),
    .fixed_point_in(fixed_point_in), .NaR_in(NaR_in), .busy(busy),
    .fp16_out(fp16_out), .done(done), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Unsigned magnitude of a 32-bit two's-complement value.
  function automatic longint mag_of(input logic [31:0] fx);
    longint m;
    m = {32'b0, fx};
    if (fx[31]) m = 64'h1_0000_0000 - m;
    return m;
  endfunction

  function automatic int msb_of(input longint m);
    int p;
    p = -1;
    for (int i = 0; i < 64; i++) if (m[i]) p = i;
    return p;
  endfunction

  // Returns {overflow, underflow, fp16}: value = fx * 2^(ex-15-14), rounded to nearest even.
  function automatic logic [17:0] ref_conv(input logic [4:0] ex, input logic [31:0] fx, input logic nar);
    longint m, q, rem, half;
    int p, e, sh;
    logic s;
    if (nar) return {2'b00, 16'h7E00};
    s = fx[31];
    m = mag_of(fx);
    if (m == 0) return 18'h0;
    p = msb_of(m);
    e = p + int'(ex) - 29 + 15;
    if (p >= 10) begin
      sh  = p - 10;
      q   = m >> sh;
      rem = m - (q << sh);
      if (sh > 0) begin
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
      end
    end else begin
      q = m << (10 - p);
    end
    if (q == 2048) begin
      q = 1024;
      e = e + 1;
    end
    if (e >= 31) return {2'b10, s, 5'h1F, 10'h000};
    if (e <= 0)  return {2'b01, s, 15'h0000};
    return {2'b00, s, e[4:0], q[9:0]};
  endfunction

  // Edges from the start edge to the done edge.
  function automatic int ref_lat(input logic [31:0] fx, input logic nar);
    longint m;
    m = mag_of(fx);
    if (nar || m == 0) return 2;
    return (31 - msb_of(m)) + 3;
  endfunction

  // Behavioural model of the observable handshake: a countdown to done and the held result.
  int          cnt = 0;
  logic [17:0] pend = '0;
  logic [17:0] held = '0;
  logic        exp_done = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      cnt = 0;
      held = '0;
      exp_done = 1'b0;
    end else begin
      exp_done = 1'b0;
      if (cnt > 0) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          held = pend;
          exp_done = 1'b1;
        end
      end else if (start) begin
        pend = ref_conv(exp_in, fixed_point_in, NaR_in);
        cnt  = ref_lat(fixed_point_in, NaR_in);
      end
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (chk_en)
      chk("cycle{busy,done,ovf,udf,fp16}",
          {12'b0, busy, done, overflow, underflow, fp16_out},
          {12'b0, (cnt != 0), exp_done, held});
  end

  // One conversion: start at the current negedge, scramble inputs after E0, wait for done.
  task automatic run(input logic [4:0] ex, input logic [31:0] fx, input logic nar,
                     output logic [17:0] res, output int lat);
    exp_in = ex;
    fixed_point_in = fx;
    NaR_in = nar;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_in = 5'($urandom);
    fixed_point_in = $urandom;
    NaR_in = 1'($urandom);
    lat = 0;
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 60) chk("done_timeout", 32'(lat), 32'd0);
    res = {overflow, underflow, fp16_out};
  endtask

  typedef struct {
    logic [4:0]  ex;
    logic [31:0] fx;
    logic        nar;
    logic [17:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [17:0] res;
    int lat;
    int ndone;

    vecs[0]  = '{5'd15, 32'h0000_4000, 1'b0, 18'h0_3C00, 20};
    vecs[1]  = '{5'd15, 32'hFFFF_C000, 1'b0, 18'h0_BC00, 20};
    vecs[2]  = '{5'd15, 32'h0000_4008, 1'b0, 18'h0_3C00, 20};
    vecs[3]  = '{5'd15, 32'h0000_4018, 1'b0, 18'h0_3C02, 20};
    vecs[4]  = '{5'd0,  32'h7FFF_FFFF, 1'b0, 18'h0_4400, 4};
    vecs[5]  = '{5'd31, 32'h7FFF_FFFF, 1'b0, 18'h2_7C00, 4};
    vecs[6]  = '{5'd7,  32'h0000_0000, 1'b0, 18'h0_0000, 2};
    vecs[7]  = '{5'd3,  32'h1234_5678, 1'b1, 18'h0_7E00, 2};
    vecs[8]  = '{5'd0,  32'h0000_0001, 1'b0, 18'h1_0000, 34};
    vecs[9]  = '{5'd0,  32'hFFFF_FFFF, 1'b0, 18'h1_8000, 34};
    vecs[10] = '{5'd20, 32'h8000_0000, 1'b0, 18'h2_FC00, 3};

    rst = 1'b0;
    start = 1'b0;
    exp_in = '0;
    fixed_point_in = '0;
    NaR_in = 1'b0;

    // Pin the reference model itself to hand-computed values.
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("model_res[%0d]", i), 32'(ref_conv(vecs[i].ex, vecs[i].fx, vecs[i].nar)), 32'(vecs[i].res));
      chk($sformatf("model_lat[%0d]", i), 32'(ref_lat(vecs[i].fx, vecs[i].nar)), 32'(vecs[i].lat));
    end

    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_state", {11'b0, busy, done, overflow, underflow, fp16_out}, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Directed cases, issued back-to-back from each done cycle.
    for (int i = 0; i < 11; i++) begin
      run(vecs[i].ex, vecs[i].fx, vecs[i].nar, res, lat);
      chk($sformatf("dir_res[%0d]", i), 32'(res), 32'(vecs[i].res));
      chk($sformatf("dir_lat[%0d]", i), 32'(lat), 32'(vecs[i].lat));
    end

    // A start pulsed mid-conversion must be ignored.
    exp_in = 5'd15;
    fixed_point_in = 32'h0000_4000;
    NaR_in = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    exp_in = 5'd20;
    fixed_point_in = 32'hFFFF_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        chk("midstart_res", {14'b0, overflow, underflow, fp16_out}, 32'h0_3C00);
      end
    end
    chk("midstart_done_count", 32'(ndone), 32'd1);

    // Reset while normalising aborts without a done.
    exp_in = 5'd15;
    fixed_point_in = 32'h0000_4000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("abort_state", {11'b0, busy, done, overflow, underflow, fp16_out}, 32'h0);
    ndone = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    run(5'd15, 32'hFFFF_C000, 1'b0, res, lat);
    chk("post_abort_res", 32'(res), 32'h0_BC00);
    chk("post_abort_lat", 32'(lat), 32'd20);

    // Randomised conversions against the model.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] r;
      logic [4:0]  ex;
      logic        nar;
      r = $urandom;
      r = r >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) r = -r;
      if ($urandom_range(0, 15) == 0) r = 32'h0;
      if ($urandom_range(0, 31) == 0) r = 32'h8000_0000;
      ex  = 5'($urandom_range(0, 31));
      nar = ($urandom_range(0, 15) == 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run(ex, r, nar, res, lat);
      chk("rand_res", 32'(res), 32'(ref_conv(ex, r, nar)));
      chk("rand_lat", 32'(lat), 32'(ref_lat(r, nar)));
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
